// File: rtl/lsq_moment_acc.sv
// lsq_moment_acc: streams (x, y) samples and accumulates polynomial least-squares moments
//   S_k = sum x^k     for k = 0..2*DEG
//   T_k = sum y*x^k   for k = 0..DEG
// The sample count is programmed per run. Results are held in DONE until out_ready.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, num_samples begin a run (sampled only in IDLE), samples for this run
//   in_valid/in_ready  sample handshake, x_in/y_in unsigned sample
//   busy               high in ACC, DRAIN and DONE
//   out_valid/ready    result handshake
//   s_out, t_out       packed moment lanes, lane 0 in the LSBs
module lsq_moment_acc #(
   parameter int unsigned XW   = 16,
   parameter int unsigned YW   = 16,
   parameter int unsigned DEG  = 2,
   parameter int unsigned CNTW = 10
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic [CNTW-1:0]                             num_samples,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [XW-1:0]                               x_in,
   input  logic [YW-1:0]                               y_in,
   output logic                                        busy,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [(2*DEG+1)*(2*DEG*XW+CNTW)-1:0]        s_out,
   output logic [(DEG+1)*(DEG*XW+YW+CNTW)-1:0]         t_out
);

   localparam int unsigned SW = 2*DEG*XW + CNTW;
   localparam int unsigned TW = DEG*XW + YW + CNTW;
   localparam int unsigned NS = 2*DEG + 1;
   localparam int unsigned NT = DEG + 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAcc   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [CNTW-1:0] n_q, n_d;
   logic            s1_valid_q;
   logic [XW-1:0]   s1_x_q;
   logic [YW-1:0]   s1_y_q;
   logic [SW-1:0]   s_acc_q [NS];
   logic [SW-1:0]   s_acc_d [NS];
   logic [TW-1:0]   t_acc_q [NT];
   logic [TW-1:0]   t_acc_d [NT];
   logic [SW-1:0]   pw      [NS];
   logic [TW-1:0]   ty      [NT];
   logic            clear;
   logic            hs;

   assign in_ready  = (state_q == StAcc) && (count_q < n_q);
   assign hs        = in_valid & in_ready;
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);

   // Control FSM and sample counter
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      n_d     = n_q;
      clear   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               clear   = 1'b1;
               n_d     = num_samples;
               count_d = '0;
               state_d = (num_samples == '0) ? StDone : StAcc;
            end
         end
         StAcc: begin
            if (hs) begin
               count_d = count_q + CNTW'(1);
               if ((count_q + CNTW'(1)) == n_q) state_d = StDrain;
            end
         end
         StDrain: state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stage 2: power chain from the stage-1 sample. Every x^k fits in SW and every
   // y*x^k (k <= DEG) fits in TW, so the truncating casts never drop bits.
   always_comb begin
      pw[0] = SW'(1);
      for (int k = 1; k < NS; k++) begin
         pw[k] = pw[k-1] * SW'(s1_x_q);
      end
      for (int k = 0; k < NT; k++) begin
         ty[k] = TW'(s1_y_q) * TW'(pw[k]);
      end
   end

   always_comb begin
      for (int k = 0; k < NS; k++) begin
         s_acc_d[k] = s_acc_q[k];
         if (clear)           s_acc_d[k] = '0;
         else if (s1_valid_q) s_acc_d[k] = s_acc_q[k] + pw[k];
      end
      for (int k = 0; k < NT; k++) begin
         t_acc_d[k] = t_acc_q[k];
         if (clear)           t_acc_d[k] = '0;
         else if (s1_valid_q) t_acc_d[k] = t_acc_q[k] + ty[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         count_q    <= '0;
         n_q        <= '0;
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         for (int k = 0; k < NS; k++) s_acc_q[k] <= '0;
         for (int k = 0; k < NT; k++) t_acc_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         n_q        <= n_d;
         s1_valid_q <= hs;
         if (hs) begin
            s1_x_q <= x_in;
            s1_y_q <= y_in;
         end
         for (int k = 0; k < NS; k++) s_acc_q[k] <= s_acc_d[k];
         for (int k = 0; k < NT; k++) t_acc_q[k] <= t_acc_d[k];
      end
   end

   // The accumulators are the result registers; they hold until the next accepted start.
   for (genvar k = 0; k < NS; k++) begin : g_s_out
      assign s_out[k*SW +: SW] = s_acc_q[k];
   end
   for (genvar k = 0; k < NT; k++) begin : g_t_out
      assign t_out[k*TW +: TW] = t_acc_q[k];
   end

endmodule
